// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status, Cause, EPC, BadVAddr, Count and Compare,
// plus commit-stage arbitration that drives the pipeline flush and PC redirect.
module cp0_exc_ctrl #(
  parameter int unsigned N_HWINT     = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [4:0]         waddr,
  input  logic [31:0]        wdata,
  input  logic [4:0]         raddr,
  output logic [31:0]        rdata,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic               exc_badvaddr_we,
  input  logic [31:0]        exc_badvaddr,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic               commit_bd,
  input  logic               eret,
  input  logic [N_HWINT-1:0] hw_int,
  output logic               flush,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc_o,
  output logic               status_exl,
  output logic               timer_int
);

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(COUNT_DIV - 1);

  logic [N_HWINT-1:0] sync_q [SYNC_STAGES];
  logic [N_HWINT-1:0] ip_hw_q;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   epc_q, epc_d;
  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [7:0]    im_q, im_d;
  logic          exl_q, exl_d;
  logic          ie_q, ie_d;
  logic          bd_q, bd_d;
  logic          ti_q, ti_d;
  logic [1:0]    ip_sw_q, ip_sw_d;
  logic [4:0]    code_q, code_d;

  logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic       count_upd;
  logic [5:0] ip_hw_ext;
  logic [7:0] ip;
  logic       int_pend;
  logic       take_int, take_evt, take_eret;

  assign wr_count   = we && (waddr == RegCount);
  assign wr_compare = we && (waddr == RegCompare);
  assign wr_status  = we && (waddr == RegStatus);
  assign wr_cause   = we && (waddr == RegCause);
  assign wr_epc     = we && (waddr == RegEpc);

  always_comb begin
    ip_hw_ext = '0;
    ip_hw_ext[N_HWINT-1:0] = ip_hw_q;
  end

  // The timer shares the top interrupt line with the last hardware input.
  assign ip       = {ip_hw_ext[5] | ti_q, ip_hw_ext[4:0], ip_sw_q};
  assign int_pend = ie_q & ~exl_q & (|(ip & im_q));

  assign take_int  = ~exc_valid & int_pend & commit_valid;
  assign take_evt  = exc_valid | take_int;
  assign take_eret = ~take_evt & eret;

  assign flush = take_evt | take_eret;

  always_comb begin
    redirect_pc = '0;
    if (take_evt) begin
      redirect_pc = EXC_VECTOR;
    end else if (take_eret) begin
      redirect_pc = epc_q;
    end
  end

  assign epc_o      = epc_q;
  assign status_exl = exl_q;
  assign timer_int  = ti_q;

  always_comb begin
    rdata = '0;
    case (raddr)
      RegBadVAddr: rdata = badvaddr_q;
      RegCount:    rdata = count_q;
      RegCompare:  rdata = compare_q;
      RegStatus:   rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
      RegCause:    rdata = {bd_q, ti_q, 14'b0, ip, 1'b0, code_q, 2'b00};
      RegEpc:      rdata = epc_q;
      default:     rdata = '0;
    endcase
  end

  // Count / Compare / timer interrupt
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    count_upd = 1'b0;
    if (wr_count) begin
      count_d   = wdata;
      presc_d   = '0;
      count_upd = 1'b1;
    end else if (presc_q == PrescMax) begin
      count_d   = count_q + 32'd1;
      presc_d   = '0;
      count_upd = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    compare_d = wr_compare ? wdata : compare_q;

    ti_d = ti_q;
    if (count_upd && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
    // Writing Compare acknowledges the timer even if it matches this cycle.
    if (wr_compare) begin
      ti_d = 1'b0;
    end
  end

  // Status / Cause / EPC / BadVAddr
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    bd_d       = bd_q;
    code_d     = code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (wr_status) begin
      im_d  = wdata[15:8];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (wr_cause) begin
      ip_sw_d = wdata[9:8];
    end
    if (wr_epc) begin
      epc_d = wdata;
    end

    // Events override software writes to EXL, EPC, BD and ExcCode.
    if (take_evt) begin
      exl_d  = 1'b1;
      code_d = exc_valid ? exc_code : 5'd0;
      epc_d  = epc_q;
      if (!exl_q) begin
        epc_d = commit_pc;
        bd_d  = commit_bd;
      end
      if (exc_badvaddr_we) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (take_eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      ip_hw_q <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      ip_hw_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      code_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      code_q     <= code_d;
    end
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Second-generation CP0 block: Status/Cause/EPC/BadVAddr/Count/Compare registers plus exception and interrupt arbitration.
- Adds precise interrupts (synchronised hardware lines, software interrupts, timer), EXL nesting, branch-delay tracking, ERET return and a pipeline flush/redirect output.
- Sits beside the commit stage: it accepts one exception or interrupt per cycle and steers the PC mux.

Parameters:
- N_HWINT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+N_HWINT-1:2].
- COUNT_DIV, 2, Count increments once every COUNT_DIV clk cycles (>=1).
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception and interrupt.
- SYNC_STAGES, 2, flop stages on each hw_int line (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- we  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 register number
- rdata  out  32  MFC0 data, combinational from current register state
- exc_valid  in  1  synchronous exception at commit
- exc_code  in  5  ExcCode for exc_valid
- exc_badvaddr_we  in  1  exception carries a bad address (AdEL/AdES)
- exc_badvaddr  in  32  faulting address
- commit_valid  in  1  an instruction boundary is committing this cycle
- commit_pc  in  32  PC of the excepting/committing instruction (branch PC if commit_bd)
- commit_bd  in  1  instruction is in a branch delay slot
- eret  in  1  ERET committing
- hw_int  in  N_HWINT  asynchronous level interrupt lines
- flush  out  1  take exception/interrupt or ERET this cycle (combinational)
- redirect_pc  out  32  EXC_VECTOR on exception/interrupt, EPC on ERET; 0 otherwise
- epc_o  out  32  EPC register
- status_exl  out  1  Status.EXL
- timer_int  out  1  Cause.TI

Behaviour:
- Register numbers: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. All others read 0; writes to them are ignored.
- Reset: all registers 0; synchronisers 0; Count prescaler 0. Outputs at reset: flush=0, redirect_pc=0, status_exl=0, timer_int=0, epc_o=0.
- Status writable fields: IM[15:8], EXL[1], IE[0]. All other bits read 0.
- Cause fields:
  - BD[31] and TI[30]: hardware only.
  - IP[15:10]: synchronised hw_int, with the timer ORed into IP[15]. Read-only.
  - IP[9:8]: software interrupts, MTC0-writable.
  - ExcCode[6:2]: hardware only. All other bits read 0.
- Count: increments by 1 (mod 2^32) when the prescaler reaches COUNT_DIV-1. An MTC0 to Count loads wdata and clears the prescaler.
- Timer: TI sets on the cycle Count is updated to a value equal to Compare. TI stays set until an MTC0 to Compare, which clears it. A simultaneous set and clear means clear wins.
- int_pend = IE & ~EXL & |(IP & IM), evaluated on registered state.
- Arbitration, one event per cycle, highest first:
  1. exc_valid
  2. interrupt (int_pend & commit_valid), ExcCode 0
  3. eret
- On an exception or interrupt:
  - flush=1, redirect_pc=EXC_VECTOR.
  - At the edge: ExcCode <= code; EXL <= 1.
  - If EXL was 0: EPC <= commit_pc and BD <= commit_bd. If EXL was already 1 (nested), EPC and BD are held.
  - BadVAddr <= exc_badvaddr when exc_badvaddr_we.
- On ERET (no higher event): flush=1, redirect_pc=EPC (pre-edge value), EXL <= 0.
- An ERET losing arbitration is dropped; the pipeline replays it.
- MTC0 in the same cycle as an event: the event wins for EXL, EPC, Cause.BD and ExcCode. All other MTC0 fields still apply.
- MFC0 in the same cycle as a write returns the old value.
- Interrupt latency: from hw_int assertion to int_pend is SYNC_STAGES+1 cycles, then taken at the next commit_valid.
- Async reset mid-handler clears EXL and EPC immediately. flush deasserts combinationally.

Test Plan:
- Reset, then exc_valid with code 8, commit_pc=0x0040_0010, commit_bd=0 → flush=1, redirect_pc=0xBFC0_0380; next cycle EPC=0x0040_0010, Cause=0x0000_0020, Status.EXL=1.
- Nested exception while EXL=1, code 12, commit_pc=0x0040_0100 → EPC remains 0x0040_0010, ExcCode=12, BD unchanged. Then ERET → redirect_pc=0x0040_0010, EXL=0 next cycle.
- Status=0x0000_0401, hw_int[0] raised, commit_valid=1 → flush exactly SYNC_STAGES+1 cycles later, ExcCode=0, Cause.IP[10]=1. Repeat with IE=0 or IM[10]=0 → no flush.
- Compare=5, Count=0, COUNT_DIV=2 → TI and Cause.IP[15] set 10 cycles after the Count write. MTC0 Compare=20 → TI=0 next cycle.
- Same cycle: exc_valid (AdEL, code 4, exc_badvaddr=0x1003) + eret + MTC0 EPC=0xDEAD → exception wins: EPC=commit_pc, BadVAddr=0x1003, EXL=1, eret ignored.
- commit_bd=1 with interrupt at commit_pc=0x0040_0020 → EPC=0x0040_0020, Cause bit 31=1. Assert rst mid-handler → all registers 0 immediately.
